// File: rtl/eth_parser_pkg.sv
// -----------------------------------------------------------------------------
// eth_parser_pkg
// Shared types and constants for the Ethernet L2 header parser.
//   mac_addr_t      48-bit MAC address, most significant byte = first wire byte
//   ethertype_t     16-bit ethertype
//   eth_metadata_t  parsed header record presented by eth_header_pipeline
// -----------------------------------------------------------------------------
package eth_parser_pkg;

    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    localparam ethertype_t ETYPE_IPV4 = 16'h0800;
    localparam ethertype_t ETYPE_IPV6 = 16'h86DD;
    localparam ethertype_t ETYPE_ARP  = 16'h0806;
    localparam ethertype_t ETYPE_VLAN = 16'h8100;

    localparam logic [4:0] L2_LEN_PLAIN = 5'd14;
    localparam logic [4:0] L2_LEN_VLAN  = 5'd18;

    typedef struct packed {
        mac_addr_t   dest_mac;
        mac_addr_t   src_mac;
        ethertype_t  ethertype;      // resolved (inner) ethertype
        logic        vlan_present;
        logic [11:0] vlan_id;
        logic [4:0]  l2_header_len;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        is_unknown;
    } eth_metadata_t;

endpackage

// File: rtl/eth_header_pipeline_hsr.sv
// -----------------------------------------------------------------------------
// header_shift_register
// Captures the first HDR_BYTES bytes of a frame from the beat stream.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_start_i       start-of-frame pulse (may coincide with beat 0)
//   frame_end_i         end-of-frame pulse
//   beat_accept_i       tdata_i carries an accepted beat
//   tdata_i             beat data, byte 0 in [7:0]
//   hdr_bytes_o         captured header, header byte n in [8n+7:8n]
//   hdr_done_o          all header beats of the current frame captured
//   frame_active_o      inside a frame (between frame_start and frame_end)
// -----------------------------------------------------------------------------
module header_shift_register #(
    parameter int TDATA_W   = 64,
    parameter int HDR_BYTES = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start_i,
    input  logic                   frame_end_i,
    input  logic                   beat_accept_i,
    input  logic [TDATA_W-1:0]     tdata_i,
    output logic [HDR_BYTES*8-1:0] hdr_bytes_o,
    output logic                   hdr_done_o,
    output logic                   frame_active_o
);

    localparam int BPB       = TDATA_W / 8;
    localparam int NUM_BEATS = (HDR_BYTES + BPB - 1) / BPB;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS + 1) : 1;

    logic [HDR_BYTES*8-1:0] hdr_q, hdr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   active_q, active_d;
    logic                   take;
    logic [CNT_W-1:0]       idx;

    // A beat arriving with frame_start belongs to the new frame as beat 0,
    // otherwise beats count only while a frame is open and still short.
    assign take = beat_accept_i && (frame_start_i || (active_q && !done_q));
    assign idx  = frame_start_i ? '0 : cnt_q;

    always_comb begin
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        active_d = active_q;
        if (frame_start_i) begin
            active_d = 1'b1;
            done_d   = 1'b0;
            cnt_d    = '0;
        end else if (frame_end_i) begin
            active_d = 1'b0;
        end
        if (take) begin
            for (int b = 0; b < HDR_BYTES; b++) begin
                if (CNT_W'(b / BPB) == idx)
                    hdr_d[b*8 +: 8] = tdata_i[(b % BPB)*8 +: 8];
            end
            cnt_d = idx + 1'b1;
            if (idx == CNT_W'(NUM_BEATS - 1))
                done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    assign hdr_bytes_o    = hdr_q;
    assign hdr_done_o     = done_q;
    assign frame_active_o = active_q;

endmodule

// File: rtl/eth_header_pipeline.sv
// -----------------------------------------------------------------------------
// eth_header_pipeline
// Captures the L2 header of each frame and presents a registered, classified
// metadata record one cycle after the last header beat is taken.
// Build option: define ETH_PARSER_VLAN_EN to resolve a single 802.1Q tag;
// without it 0x8100 is reported as an ordinary (unknown) ethertype.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   frame_start     start-of-frame pulse
//   frame_end       end-of-frame pulse
//   beat_accept     axis_tdata carries an accepted beat
//   axis_tdata      beat data, earliest wire byte in [7:0]
//   metadata        parsed header record
//   metadata_valid  metadata belongs to the current frame
// -----------------------------------------------------------------------------
module eth_header_pipeline
    import eth_parser_pkg::*;
#(
    parameter int TDATA_W   = 64,
    parameter int HDR_BYTES = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               beat_accept,
    input  logic [TDATA_W-1:0] axis_tdata,
    output eth_metadata_t      metadata,
    output logic               metadata_valid
);

    logic [HDR_BYTES*8-1:0] hdr_bytes;
    logic                   hdr_done;
    logic                   frame_active;

    header_shift_register #(
        .TDATA_W   (TDATA_W),
        .HDR_BYTES (HDR_BYTES)
    ) u_hsr (
        .clk            (clk),
        .rst            (rst),
        .frame_start_i  (frame_start),
        .frame_end_i    (frame_end),
        .beat_accept_i  (beat_accept),
        .tdata_i        (axis_tdata),
        .hdr_bytes_o    (hdr_bytes),
        .hdr_done_o     (hdr_done),
        .frame_active_o (frame_active)
    );

    mac_addr_t     dmac, smac;
    ethertype_t    etype_raw, etype_inner, etype;
    logic [11:0]   vid;
    logic          vlan_hit;
    eth_metadata_t meta_d;

    // PCP/DEI bits of the tag are not reported.
    logic unused_tci_hi;
    assign unused_tci_hi = ^hdr_bytes[8*14+4 +: 4];

    always_comb begin
        dmac = '0;
        smac = '0;
        for (int i = 0; i < 6; i++) begin
            dmac[8*(5-i) +: 8] = hdr_bytes[8*i +: 8];
            smac[8*(5-i) +: 8] = hdr_bytes[8*(6+i) +: 8];
        end
        etype_raw   = {hdr_bytes[8*12 +: 8], hdr_bytes[8*13 +: 8]};
        etype_inner = {hdr_bytes[8*16 +: 8], hdr_bytes[8*17 +: 8]};
        vid         = {hdr_bytes[8*14 +: 4], hdr_bytes[8*15 +: 8]};
`ifdef ETH_PARSER_VLAN_EN
        vlan_hit = (etype_raw == ETYPE_VLAN);
`else
        vlan_hit = 1'b0;
`endif
        etype = vlan_hit ? etype_inner : etype_raw;

        meta_d               = '0;
        meta_d.dest_mac      = dmac;
        meta_d.src_mac       = smac;
        meta_d.ethertype     = etype;
        meta_d.vlan_present  = vlan_hit;
        meta_d.vlan_id       = vlan_hit ? vid : 12'd0;
        meta_d.l2_header_len = vlan_hit ? L2_LEN_VLAN : L2_LEN_PLAIN;
        meta_d.is_ipv4       = (etype == ETYPE_IPV4);
        meta_d.is_ipv6       = (etype == ETYPE_IPV6);
        meta_d.is_arp        = (etype == ETYPE_ARP);
        meta_d.is_unknown    = !(meta_d.is_ipv4 || meta_d.is_ipv6 || meta_d.is_arp);
    end

    // Capture once, on the cycle after hdr_done rises. A frame_end on or
    // before the capture edge leaves valid low (frame_active already clear,
    // or frame_end has priority below).
    logic          hdr_done_prev_q;
    logic          capture;
    eth_metadata_t metadata_q;
    logic          metadata_valid_q;

    assign capture = hdr_done && !hdr_done_prev_q && frame_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_done_prev_q  <= 1'b0;
            metadata_q       <= '0;
            metadata_valid_q <= 1'b0;
        end else begin
            hdr_done_prev_q <= hdr_done;
            if (capture)
                metadata_q <= meta_d;
            if (frame_start || frame_end)
                metadata_valid_q <= 1'b0;
            else if (capture)
                metadata_valid_q <= 1'b1;
        end
    end

    assign metadata       = metadata_q;
    assign metadata_valid = metadata_valid_q;

endmodule

// File: tb/tb_eth_header_pipeline.sv
module tb_eth_header_pipeline;
    import eth_parser_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start, frame_end, beat_accept;
    logic [63:0]   axis_tdata;
    eth_metadata_t metadata;
    logic          metadata_valid;

    int checks = 0;
    int errors = 0;
    eth_metadata_t exp_q[$];

    always #5 clk = ~clk;

    eth_header_pipeline #(.TDATA_W(64), .HDR_BYTES(18)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .beat_accept    (beat_accept),
        .axis_tdata     (axis_tdata),
        .metadata       (metadata),
        .metadata_valid (metadata_valid)
    );

    // Reference record built from the header fields, not from wire bytes.
    function automatic eth_metadata_t model(input mac_addr_t dm, input mac_addr_t sm,
                                            input ethertype_t et, input logic [31:0] tail);
        eth_metadata_t m;
        logic vl;
        m = '0;
`ifdef ETH_PARSER_VLAN_EN
        vl = (et == 16'h8100);
`else
        vl = 1'b0;
`endif
        m.dest_mac      = dm;
        m.src_mac       = sm;
        m.vlan_present  = vl;
        m.vlan_id       = vl ? tail[27:16] : 12'h000;
        m.ethertype     = vl ? tail[15:0] : et;
        m.l2_header_len = vl ? 5'd18 : 5'd14;
        case (m.ethertype)
            16'h0800: m.is_ipv4 = 1'b1;
            16'h86DD: m.is_ipv6 = 1'b1;
            16'h0806: m.is_arp  = 1'b1;
            default:  m.is_unknown = 1'b1;
        endcase
        return m;
    endfunction

    // Wire image of the first 24 bytes; byte n at [8n+7:8n].
    function automatic logic [191:0] mk_frame(input mac_addr_t dm, input mac_addr_t sm,
                                              input ethertype_t et, input logic [31:0] tail);
        logic [191:0] f;
        f = '0;
        for (int i = 0; i < 6; i++) begin
            f[8*i +: 8]     = dm[8*(5-i) +: 8];
            f[8*(6+i) +: 8] = sm[8*(5-i) +: 8];
        end
        f[8*12 +: 8] = et[15:8];
        f[8*13 +: 8] = et[7:0];
        for (int i = 0; i < 4; i++) f[8*(14+i) +: 8] = tail[8*(3-i) +: 8];
        return f;
    endfunction

    task automatic cyc(input logic fs, input logic fe, input logic ba, input logic [63:0] d);
        frame_start = fs; frame_end = fe; beat_accept = ba; axis_tdata = d;
        @(posedge clk); #1;
        frame_start = 1'b0; frame_end = 1'b0; beat_accept = 1'b0; axis_tdata = '0;
    endtask

    task automatic send_beats(input logic [191:0] f, input int nbeats);
        for (int k = 0; k < nbeats; k++) cyc(k == 0, 1'b0, 1'b1, f[64*k +: 64]);
    endtask

    // Bounded wait for metadata_valid; n = edges waited (8 means timeout).
    task automatic wait_valid(output int n);
        n = 0;
        while (!metadata_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; frame_start = 0; frame_end = 0; beat_accept = 0; axis_tdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (metadata_valid !== 1'b0 || metadata !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b meta=%h, want 0/0", metadata_valid, metadata);
        end
    endtask

    task automatic test_ipv4;
        logic [191:0] f;
        eth_metadata_t e;
        int n;
        f = mk_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 32'h0);
        exp_q.push_back(model(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 32'h0));
        send_beats(f, 3);
        checks++;
        if (metadata_valid !== 1'b0) begin
            errors++; $display("FAIL ipv4_early: valid=%b one edge after beat 2, want 0", metadata_valid);
        end
        wait_valid(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 1) begin errors++; $display("FAIL ipv4_latency: %0d edges, want 1", n); end
        checks++;
        if (metadata !== e) begin errors++; $display("FAIL ipv4_meta: got %h want %h", metadata, e); end
        // extra beat and idle cycles must not disturb the held record
        cyc(1'b0, 1'b0, 1'b1, 64'hDEADBEEFCAFEF00D);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (metadata_valid !== 1'b1 || metadata !== e) begin
            errors++; $display("FAIL ipv4_hold: valid=%b meta=%h want 1/%h", metadata_valid, metadata, e);
        end
        cyc(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (metadata_valid !== 1'b0) begin errors++; $display("FAIL ipv4_end_clear: valid=%b want 0", metadata_valid); end
    endtask

    task automatic test_vlan;
        logic [191:0] f;
        eth_metadata_t e;
        int n;
        f = mk_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h8100, 32'h2ABC86DD);
        exp_q.push_back(model(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h8100, 32'h2ABC86DD));
        send_beats(f, 3);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 1) begin errors++; $display("FAIL vlan_latency: %0d edges, want 1", n); end
        checks++;
        if (metadata !== e) begin errors++; $display("FAIL vlan_meta: got %h want %h", metadata, e); end
        cyc(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_classify;
        ethertype_t ets[4];
        logic [191:0] f;
        eth_metadata_t e;
        mac_addr_t dm, sm;
        int n;
        ets[0] = 16'h0806; ets[1] = 16'h1234; ets[2] = 16'h86DD; ets[3] = 16'h0800;
        for (int t = 0; t < 4; t++) begin
            dm = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
            sm = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
            f  = mk_frame(dm, sm, ets[t], $urandom);
            f[8*14 +: 32] = 32'h5A5A5A5A;
            exp_q.push_back(model(dm, sm, ets[t], 32'h5A5A5A5A));
            send_beats(f, 3);
            checks++;
            if (metadata_valid !== 1'b0) begin errors++; $display("FAIL class_early_%h: valid=%b want 0", ets[t], metadata_valid); end
            wait_valid(n);
            e = exp_q.pop_front();
            checks++;
            if (n !== 1) begin errors++; $display("FAIL class_latency_%h: %0d edges, want 1", ets[t], n); end
            checks++;
            if (metadata !== e) begin errors++; $display("FAIL class_meta_%h: got %h want %h", ets[t], metadata, e); end
            cyc(1'b0, 1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_end_with_capture;
        logic [191:0] f;
        logic seen;
        f = mk_frame(48'h111111111111, 48'h222222222222, 16'h0800, 32'h0);
        send_beats(f, 3);
        cyc(1'b0, 1'b1, 1'b0, '0);   // frame_end on the capture edge
        seen = metadata_valid;
        repeat (3) begin @(posedge clk); #1; seen |= metadata_valid; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL end_wins: valid=%b want 0", seen); end
    endtask

    task automatic test_early_end;
        logic [191:0] f;
        eth_metadata_t e;
        logic seen;
        int n;
        f = mk_frame(48'h333333333333, 48'h444444444444, 16'h0806, 32'h0);
        send_beats(f, 2);
        cyc(1'b0, 1'b1, 1'b0, '0);
        seen = metadata_valid;
        cyc(1'b0, 1'b0, 1'b1, f[128 +: 64]);
        seen |= metadata_valid;
        repeat (4) begin @(posedge clk); #1; seen |= metadata_valid; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL early_end: valid=%b want 0", seen); end
        f = mk_frame(48'h555555555555, 48'h666666666666, 16'h86DD, 32'h0);
        exp_q.push_back(model(48'h555555555555, 48'h666666666666, 16'h86DD, 32'h0));
        send_beats(f, 3);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 1 || metadata !== e) begin
            errors++; $display("FAIL after_early_end: edges=%0d meta=%h want 1/%h", n, metadata, e);
        end
        cyc(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_back_to_back;
        logic [191:0] fa, fb;
        eth_metadata_t e;
        int n;
        fa = mk_frame(48'h777777777777, 48'h888888888888, 16'h0800, 32'h0);
        fb = mk_frame(48'h999999999999, 48'hAAAAAAAAAAAA, 16'h0806, 32'h0);
        exp_q.push_back(model(48'h777777777777, 48'h888888888888, 16'h0800, 32'h0));
        exp_q.push_back(model(48'h999999999999, 48'hAAAAAAAAAAAA, 16'h0806, 32'h0));
        send_beats(fa, 3);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++;
        if (metadata !== e) begin errors++; $display("FAIL b2b_a: got %h want %h", metadata, e); end
        // new frame_start (with beat 0) while A is still valid
        cyc(1'b1, 1'b0, 1'b1, fb[63:0]);
        checks++;
        if (metadata_valid !== 1'b0) begin errors++; $display("FAIL b2b_start_clear: valid=%b want 0", metadata_valid); end
        cyc(1'b0, 1'b0, 1'b1, fb[127:64]);
        cyc(1'b0, 1'b0, 1'b1, fb[191:128]);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 1 || metadata !== e) begin
            errors++; $display("FAIL b2b_b: edges=%0d meta=%h want 1/%h", n, metadata, e);
        end
        cyc(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_reset_mid;
        logic [191:0] f;
        logic seen;
        int n;
        f = mk_frame(48'hBBBBBBBBBBBB, 48'hCCCCCCCCCCCC, 16'h0800, 32'h0);
        send_beats(f, 3);
        wait_valid(n);
        send_beats(f, 2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (metadata_valid !== 1'b0 || metadata !== '0) begin
            errors++; $display("FAIL reset_async: valid=%b meta=%h want 0/0", metadata_valid, metadata);
        end
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b1, f[64*(k%3) +: 64]);
            seen |= metadata_valid;
        end
        repeat (3) begin @(posedge clk); #1; seen |= metadata_valid; end
        checks++;
        if (seen !== 1'b0 || metadata !== '0) begin
            errors++; $display("FAIL reset_no_start: valid=%b meta=%h want 0/0", seen, metadata);
        end
    endtask

    initial begin
        test_reset;
        test_ipv4;
        test_vlan;
        test_classify;
        test_end_with_capture;
        test_early_end;
        test_back_to_back;
        test_reset_mid;
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
